// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The slave modport is the ALU side; the master modport is the source/writeback side.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_carry, out_zero, out_neg, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_carry, out_zero, out_neg, out_ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with carry/zero/neg/ovf flags and a wrapping delivered-result counter.
// Optional macro ALU_PIPE_BARREL_SHIFT_EN: SHL/SHR shift by in_b[$clog2(WIDTH)-1:0] instead of by one.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_pipe_if.slave        bus,
  output logic [CNT_W-1:0] res_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  // Handshake: a beat moves on a rising edge only when valid && ready are both high on that
  // side; valid never depends on ready, and ready depends only on registered state and out_ready.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic             s2_carry;
  logic             s2_zero;
  logic             s2_neg;
  logic             s2_ovf;

  logic             s2_adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;

`ifdef ALU_PIPE_BARREL_SHIFT_EN
  localparam int SH_W = $clog2(WIDTH);
  logic [SH_W-1:0]    shamt;
  logic [2*WIDTH-1:0] wide;
  assign shamt = s1_b[SH_W-1:0];
`endif

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
`ifdef ALU_PIPE_BARREL_SHIFT_EN
    wide  = '0;
`endif
    unique case (s1_op)
      OP_ADD: begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        sum   = {1'b0, s1_a} - {1'b0, s1_b};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
`ifdef ALU_PIPE_BARREL_SHIFT_EN
      // Shifting in a double-width word leaves the last bit shifted out next to the result.
      OP_SHL: begin
        wide  = {{WIDTH{1'b0}}, s1_a} << shamt;
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_SHR: begin
        wide  = {s1_a, {WIDTH{1'b0}}} >> shamt;
        res   = wide[2*WIDTH-1:WIDTH];
        carry = wide[WIDTH-1];
      end
`else
      OP_SHL: begin
        res   = {s1_a[WIDTH-2:0], 1'b0};
        carry = s1_a[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, s1_a[WIDTH-1:1]};
        carry = s1_a[0];
      end
`endif
      OP_NOT: res = ~s1_a;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_op <= bus.in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_carry <= 1'b0;
      s2_zero  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= res;
        s2_carry <= carry;
        s2_zero  <= (res == '0);
        s2_neg   <= res[WIDTH-1];
        s2_ovf   <= ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= '0;
    end else if (s2_valid && bus.out_ready) begin
      res_count <= res_count + 1'b1;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_res   = s2_res;
  assign bus.out_carry = s2_carry;
  assign bus.out_zero  = s2_zero;
  assign bus.out_neg   = s2_neg;
  assign bus.out_ovf   = s2_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: arithmetic model + expected queue checked on every negedge,
// with literal expectations for latency, flags, stall, counter wrap and async reset.
module tb_alu_pipe;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int OW = W + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  logic [CW-1:0] res_count;

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .res_count (res_count)
  );

  logic [OW-1:0] dut_out;
  assign dut_out = {bus.out_res, bus.out_carry, bus.out_zero, bus.out_neg, bus.out_ovf};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected {res, carry, zero, neg, ovf} from plain integer arithmetic.
  function automatic logic [OW-1:0] model(input int a, input int b, input int op);
    int m, h, sa, sb, r, c, v, s;
    m = (1 << W) - 1;
    h = 1 << (W - 1);
    sa = (a >= h) ? a - (1 << W) : a;
    sb = (b >= h) ? b - (1 << W) : b;
    c = 0;
    v = 0;
    s = b % (1 << $clog2(W));
    case (op)
      0: begin r = (a + b) & m; c = (a + b > m) ? 1 : 0; v = (sa + sb > h - 1 || sa + sb < -h) ? 1 : 0; end
      1: begin r = (a - b) & m; c = (a < b) ? 1 : 0;     v = (sa - sb > h - 1 || sa - sb < -h) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
`ifdef ALU_PIPE_BARREL_SHIFT_EN
      5: begin r = (a << s) & m; c = (s > 0) ? (a >> (W - s)) & 1 : 0; end
      6: begin r = a >> s;       c = (s > 0) ? (a >> (s - 1)) & 1 : 0; end
`else
      5: begin r = (a * 2) & m; c = (a >= h) ? 1 : 0; end
      6: begin r = a / 2;       c = a % 2; end
`endif
      default: r = (~a) & m;
    endcase
    return {r[W-1:0], c[0], (r == 0), (r >= h), v[0]};
  endfunction

  // Scoreboard: push model result on each accept, pop and compare on each delivery.
  logic [OW-1:0] exp_q[$];
  int            model_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("res_count", 32'(res_count), model_cnt);
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_hold", 32'(dut_out), 32'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_beat actual=%0h required=none", dut_out);
        end else begin
          chk("out_beat", 32'(dut_out), 32'(exp_q.pop_front()));
        end
        model_cnt = (model_cnt + 1) % (1 << CW);
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.in_a), int'(bus.in_b), int'(bus.in_op)));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = dut_out;
    end
  end

  // Single beat into an empty pipe; checks 2-cycle latency and the literal result.
  task automatic lat_beat(input string nm, input int a, input int b, input int op, input logic [OW-1:0] lit);
    chk({nm, "_model"}, 32'(model(a, b, op)), 32'(lit));
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = W'(a); bus.in_b = W'(b); bus.in_op = 3'(op);
    bus.out_ready = 1'b1;
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_lat1"}, 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, 32'(bus.out_valid), 1);
    chk({nm, "_res"}, 32'(dut_out), 32'(lit));
    @(posedge clk); #1;
  endtask

  task automatic drive(input int a, input int b, input int op);
    bus.in_valid = 1'b1; bus.in_a = W'(a); bus.in_b = W'(b); bus.in_op = 3'(op);
  endtask

  logic [OW-1:0] stream_lit [8];
  int st_a [4] = '{8'h10, 8'h30, 8'hF0, 8'h01};
  int st_b [4] = '{8'h20, 8'h05, 8'h3C, 8'h00};
  int st_op[4] = '{0, 1, 4, 5};

  initial begin
    int acc, guard;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    stream_lit[0] = {8'hFF, 4'b0010};
    stream_lit[1] = {8'h55, 4'b0001};
    stream_lit[2] = {8'h00, 4'b0100};
    stream_lit[3] = {8'hFF, 4'b0010};
    stream_lit[4] = {8'hFF, 4'b0010};
`ifdef ALU_PIPE_BARREL_SHIFT_EN
    stream_lit[5] = {8'h40, 4'b1000};
    stream_lit[6] = {8'h05, 4'b0000};
`else
    stream_lit[5] = {8'h54, 4'b1000};
    stream_lit[6] = {8'h55, 4'b0000};
`endif
    stream_lit[7] = {8'h55, 4'b0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_res_count", 32'(res_count), 0);
    chk("rst_out_res", 32'(bus.out_res), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Flag corner cases
    lat_beat("add_ff_01", 8'hFF, 8'h01, 0, {8'h00, 4'b1100});
    lat_beat("add_7f_01", 8'h7F, 8'h01, 0, {8'h80, 4'b0011});
    lat_beat("sub_05_0a", 8'h05, 8'h0A, 1, {8'hFB, 4'b1010});

    // All eight ops back to back
    for (int i = 0; i < 8; i++)
      chk($sformatf("model_pin_op%0d", i), 32'(model(8'hAA, 8'h55, i)), 32'(stream_lit[i]));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(8'hAA, 8'h55, i);
      chk("stream_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", 32'(res_count), 11);

    // Backpressure: 4 beats offered during 5 stalled cycles
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      if (acc < 4) drive(st_a[acc], st_b[acc], st_op[acc]);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("stall_accepted", 32'(acc), 2);
    chk("stall_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (acc < 4 && guard < 20) begin
      drive(st_a[acc], st_b[acc], st_op[acc]);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("stall_all_accepted", 32'(acc), 4);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_count", 32'(res_count), 15);

    // Counter wraps 15 -> 0
    lat_beat("wrap_add", 8'h01, 8'h01, 0, {8'h02, 4'b0000});
    chk("wrap_count", 32'(res_count), 0);

    // Shifts
`ifdef ALU_PIPE_BARREL_SHIFT_EN
    lat_beat("shl_81_03", 8'h81, 8'h03, 5, {8'h08, 4'b0000});
    lat_beat("shr_81_03", 8'h81, 8'h03, 6, {8'h10, 4'b0000});
`else
    lat_beat("shl_81_03", 8'h81, 8'h03, 5, {8'h02, 4'b1000});
    lat_beat("shr_81_03", 8'h81, 8'h03, 6, {8'h40, 4'b1000});
`endif
    chk("pre_reset_count", 32'(res_count), 2);

    // Async reset with both stages full
    bus.out_ready = 1'b0;
    drive(8'h11, 8'h22, 0);
    @(posedge clk); #1;
    drive(8'h33, 8'h44, 3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_out_valid", 32'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_res_count", 32'(res_count), 0);
    chk("async_out_res", 32'(bus.out_res), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    lat_beat("post_rst_add", 8'h03, 8'h04, 0, {8'h07, 4'b0000});
    chk("post_rst_count", 32'(res_count), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ALU, generalised to WIDTH bits.
- Same 3-bit operation encoding.
- Adds a two-stage registered datapath with valid/ready handshakes on input and output, plus full status flags (carry, zero, negative, overflow) and a wrapping result counter.
- Sits between an operand source (register-file read / sequencer) and a writeback stage that can apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  in  1  clock; single clock domain, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/op beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation select, encoding below.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- out_res  out  WIDTH  result.
- out_carry  out  1  carry / borrow / shifted-out bit.
- out_zero  out  1  out_res == 0.
- out_neg  out  1  out_res[WIDTH-1].
- out_ovf  out  1  signed overflow (ADD/SUB only).
- res_count  out  CNT_W  number of results delivered (out_valid && out_ready), wraps.

Behaviour:
- Op encoding:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL
  - 110 SHR
  - 111 NOT
- ADD: {carry,res} = A+B, (WIDTH+1)-bit sum. ovf = (A[msb]==B[msb]) && (res[msb]!=A[msb]).
- SUB: res = A-B mod 2^WIDTH. carry = 1 on borrow (A<B unsigned). ovf = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
- SHL: res = A<<1, carry = A[WIDTH-1].
- SHR: logical, res = A>>1, carry = A[0].
- AND/OR/XOR: bitwise A,B. NOT: res = ~A, B ignored.
- AND/OR/XOR/NOT: carry = 0, ovf = 0. Shifts: ovf = 0.
- zero and neg are computed from res for every op.
- Pipeline:
  - S1 registers {A,B,op} on in_valid && in_ready.
  - S2 registers computed {res, flags} when S1 holds valid data and S2 is empty or draining.
  - Latency: beat accepted at edge N is presented with out_valid=1 after edge N+1, i.e. 2 cycles, no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Readiness rules:
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv, combinational from registered state plus out_ready.
  - No combinational path from in_valid to in_ready.
- Stall: while out_valid && !out_ready, out_res and all flags hold stable. S1 holds its beat. After both stages fill, in_ready=0.
- Simultaneous accept and deliver in one cycle is legal. No beat is dropped or duplicated.
- res_count increments by 1 on each out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Reset (async assert, any cycle including mid-stall):
  - s1_valid, s2_valid and out_valid go to 0.
  - out_res, all flags and res_count go to 0.
  - in_ready = 1 from the first edge after deassertion.
  - Beats in flight are discarded.
- Inputs are sampled only when in_valid && in_ready. Operand values at other times do not matter.

Optional Feature:
- Macro: ALU_PIPE_BARREL_SHIFT_EN.
- Defined:
  - SHL/SHR shift by amount s = in_b[$clog2(WIDTH)-1:0].
  - SHL carry = A[WIDTH-s] for s>0.
  - SHR carry = A[s-1] for s>0.
  - s=0: res = A, carry = 0.
- Undefined: shift by exactly 1 as above, and in_b is ignored for shifts.
- Handshake, latency and flags are identical in both builds.

Test Plan:
- WIDTH=8, A=0xFF B=0x01 ADD -> res=0x00 carry=1 zero=1 neg=0 ovf=0, out_valid exactly 2 cycles after accept.
- A=0x7F B=0x01 ADD -> res=0x80 ovf=1 neg=1 carry=0. A=0x05 B=0x0A SUB -> res=0xFB carry=1 neg=1 ovf=0.
- Stream all 8 ops with A=0xAA B=0x55, out_ready=1 -> back-to-back results in order:
  - 0xFF c0, 0x55 c0, 0x00 z1, 0xFF, 0xFF, 0x54 c1, 0x55 c0, 0x55.
  - in_ready stays 1. res_count=8.
- Hold out_ready=0 for 5 cycles while offering 4 beats:
  - Exactly 2 accepted, then in_ready=0.
  - out_res stable throughout.
  - On out_ready=1, all 4 beats delivered in order, none lost or duplicated.
- Assert rst_n=0 mid-stall with both stages full:
  - out_valid=0, res_count=0 and out_res=0 immediately (async).
  - After release, a new ADD 0x03+0x04 -> 0x07 after 2 cycles.
- Barrel build, WIDTH=8, A=0x81 B=0x03 SHL -> res=0x08 carry=0. SHR -> res=0x10 carry=0. Default build, same stimulus -> SHL 0x02 carry=1, SHR 0x40 carry=1.
